// File: rtl/pong_pkg.sv
// pong_pkg: shared state, direction and geometry
// definitions for the pong datapath blocks.
package pong_pkg;

    localparam int POS_W = 10;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_LEFT_PAD_X  = 100;
    localparam int DEF_RIGHT_PAD_X = 540;
    localparam int DEF_PAD_HALF    = 20;
    localparam int DEF_BALL_HALF   = 5;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_WAIT,
        PLAY
    } state_t;

    typedef logic dir_t;

    localparam dir_t DIR_LEFT  = 1'b0;
    localparam dir_t DIR_RIGHT = 1'b1;
    localparam dir_t DIR_UP    = 1'b0;
    localparam dir_t DIR_DOWN  = 1'b1;

    // Two guard bits so edge maths never wraps.
    typedef logic signed [POS_W+1:0] spos_t;

    function automatic spos_t to_s(input logic [POS_W-1:0] v);
        return spos_t'({2'b00, v});
    endfunction

    function automatic spos_t s_abs(input spos_t v);
        return v[POS_W+1] ? -v : v;
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// ball_engine_if: paddle/serve inputs and ball
// position/event outputs of the ball engine.
interface ball_engine_if;
    import pong_pkg::*;

    logic [POS_W-1:0] left_paddle_pos;
    logic [POS_W-1:0] right_paddle_pos;
    logic             serve;
    logic [POS_W-1:0] ball_x_pos;
    logic [POS_W-1:0] ball_y_pos;
    logic             ball_active;
    logic             hit;
    logic             score_left;
    logic             score_right;

    modport master (
        output left_paddle_pos, right_paddle_pos, serve,
        input  ball_x_pos, ball_y_pos, ball_active,
        input  hit, score_left, score_right
    );

    modport slave (
        input  left_paddle_pos, right_paddle_pos, serve,
        output ball_x_pos, ball_y_pos, ball_active,
        output hit, score_left, score_right
    );

endinterface

// File: rtl/ball_engine_tick_gen.sv
// tick_gen: one-clk strobe every DIV cycles,
// first strobe DIV cycles after reset release.
module tick_gen #(
    parameter int DIV = 65536
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider that wraps at DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ball_engine.sv
// ball_engine: serve FSM, ball motion, wall bounce,
// paddle hits with speed-up, and miss scoring.
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W         = DEF_SCREEN_W,
    parameter int SCREEN_H         = DEF_SCREEN_H,
    parameter int LEFT_PAD_X       = DEF_LEFT_PAD_X,
    parameter int RIGHT_PAD_X      = DEF_RIGHT_PAD_X,
    parameter int PAD_HALF         = DEF_PAD_HALF,
    parameter int BALL_HALF        = DEF_BALL_HALF,
    parameter int TICK_DIV         = 65536,
    parameter int SERVE_TICKS      = 60,
    parameter int MAX_SPEED        = 4,
    parameter int HITS_PER_SPEEDUP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    ball_engine_if.slave bus
);

    localparam int SPW = $clog2(MAX_SPEED + 1);
    localparam int HCW = $clog2(HITS_PER_SPEEDUP + 1);
    localparam int SCW = $clog2(SERVE_TICKS + 1);

    localparam logic [SPW-1:0] SPD_ONE = SPW'(1);
    localparam logic [SPW-1:0] SPD_MAX = SPW'(MAX_SPEED);
    localparam logic [HCW-1:0] HC_LAST = HCW'(HITS_PER_SPEEDUP - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SERVE_TICKS - 1);

    localparam logic [POS_W-1:0] X_C   = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0] Y_C   = POS_W'(SCREEN_H / 2);
    localparam logic [POS_W-1:0] Y_TOP = POS_W'(BALL_HALF);
    localparam logic [POS_W-1:0] Y_BOT = POS_W'(SCREEN_H - 1 - BALL_HALF);
    localparam logic [POS_W-1:0] X_RC  = POS_W'(RIGHT_PAD_X - BALL_HALF);
    localparam logic [POS_W-1:0] X_LC  = POS_W'(LEFT_PAD_X + BALL_HALF);

    localparam spos_t ZERO   = spos_t'(0);
    localparam spos_t BH     = spos_t'(BALL_HALF);
    localparam spos_t WIN    = spos_t'(PAD_HALF + BALL_HALF);
    localparam spos_t RPX    = spos_t'(RIGHT_PAD_X);
    localparam spos_t LPX    = spos_t'(LEFT_PAD_X);
    localparam spos_t X_EDGE = spos_t'(SCREEN_W - 1);
    localparam spos_t Y_EDGE = spos_t'(SCREEN_H - 1);

    logic tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    state_t           state, state_n;
    logic [POS_W-1:0] x, x_n, y, y_n;
    dir_t             dir_x, dir_x_n, dir_y, dir_y_n;
    logic [SPW-1:0]   speed, speed_n;
    logic [HCW-1:0]   hit_cnt, hit_cnt_n;
    logic [SCW-1:0]   serve_cnt, serve_cnt_n;
    logic             active, active_n;
    logic             hit, hit_n;
    logic             sc_l, sc_l_n, sc_r, sc_r_n;

    spos_t sx, sy, step, nx, ny;
    logic  r_hit, l_hit, out_r, out_l, top, bot;

    // Candidate move and all edge/paddle tests.
    always_comb begin
        sx    = to_s(x);
        sy    = to_s(y);
        step  = spos_t'(speed);
        nx    = (dir_x == DIR_RIGHT) ? sx + step : sx - step;
        ny    = (dir_y == DIR_DOWN) ? sy + step : sy - step;
        r_hit = (dir_x == DIR_RIGHT) && (sx + BH < RPX) &&
                (nx + BH >= RPX) &&
                (s_abs(sy - to_s(bus.right_paddle_pos)) <= WIN);
        l_hit = (dir_x == DIR_LEFT) && (sx - BH > LPX) &&
                (nx - BH <= LPX) &&
                (s_abs(sy - to_s(bus.left_paddle_pos)) <= WIN);
        out_r = (nx + BH >= X_EDGE);
        out_l = (nx - BH <= ZERO);
        top   = (ny - BH <= ZERO);
        bot   = (ny + BH >= Y_EDGE);
    end

    // Next-state: serve sequencing and play update.
    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        dir_x_n     = dir_x;
        dir_y_n     = dir_y;
        speed_n     = speed;
        hit_cnt_n   = hit_cnt;
        serve_cnt_n = serve_cnt;
        active_n    = active;
        hit_n       = 1'b0;
        sc_l_n      = 1'b0;
        sc_r_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.serve) begin
                    state_n     = SERVE_WAIT;
                    serve_cnt_n = '0;
                end
            end
            SERVE_WAIT: begin
                if (tick) begin
                    if (serve_cnt == SC_LAST) begin
                        state_n  = PLAY;
                        active_n = 1'b1;
                    end else begin
                        serve_cnt_n = serve_cnt + SCW'(1);
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    y_n = ny[POS_W-1:0];
                    if (top) begin
                        y_n     = Y_TOP;
                        dir_y_n = DIR_DOWN;
                    end else if (bot) begin
                        y_n     = Y_BOT;
                        dir_y_n = DIR_UP;
                    end
                    if (r_hit) begin
                        x_n     = X_RC;
                        dir_x_n = DIR_LEFT;
                    end else if (l_hit) begin
                        x_n     = X_LC;
                        dir_x_n = DIR_RIGHT;
                    end else if (out_r || out_l) begin
                        // Miss wins over any wall bounce.
                        state_n   = IDLE;
                        active_n  = 1'b0;
                        x_n       = X_C;
                        y_n       = Y_C;
                        dir_y_n   = dir_y;
                        speed_n   = SPD_ONE;
                        hit_cnt_n = '0;
                        sc_l_n    = out_r;
                        sc_r_n    = ~out_r;
                        dir_x_n   = out_r ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        x_n = nx[POS_W-1:0];
                    end
                    if (r_hit || l_hit) begin
                        hit_n = 1'b1;
                        if (hit_cnt == HC_LAST) begin
                            hit_cnt_n = '0;
                            if (speed != SPD_MAX) begin
                                speed_n = speed + SPW'(1);
                            end
                        end else begin
                            hit_cnt_n = hit_cnt + HCW'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register all state and the output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x         <= X_C;
            y         <= Y_C;
            dir_x     <= DIR_RIGHT;
            dir_y     <= DIR_DOWN;
            speed     <= SPD_ONE;
            hit_cnt   <= '0;
            serve_cnt <= '0;
            active    <= 1'b0;
            hit       <= 1'b0;
            sc_l      <= 1'b0;
            sc_r      <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            dir_x     <= dir_x_n;
            dir_y     <= dir_y_n;
            speed     <= speed_n;
            hit_cnt   <= hit_cnt_n;
            serve_cnt <= serve_cnt_n;
            active    <= active_n;
            hit       <= hit_n;
            sc_l      <= sc_l_n;
            sc_r      <= sc_r_n;
        end
    end

    assign bus.ball_x_pos  = x;
    assign bus.ball_y_pos  = y;
    assign bus.ball_active = active;
    assign bus.hit         = hit;
    assign bus.score_left  = sc_l;
    assign bus.score_right = sc_r;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: scoreboard bench with a per-clock
// reference model of the ball engine.
module tb_ball_engine;

    localparam int DIV  = 4;
    localparam int ST   = 2;
    localparam int HPS  = 2;
    localparam int MAXS = 3;
    localparam int W    = 640;
    localparam int H    = 480;
    localparam int LPX  = 100;
    localparam int RPX  = 540;
    localparam int PH   = 20;
    localparam int BH   = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ball_engine_if bus ();

    ball_engine #(
        .TICK_DIV         (DIV),
        .SERVE_TICKS      (ST),
        .MAX_SPEED        (MAXS),
        .HITS_PER_SPEEDUP (HPS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit act;
        bit hit;
        bit sl;
        bit sr;
    } snap_t;

    snap_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state: 0 idle, 1 waiting, 2 playing.
    int m_x, m_y, m_vx, m_vy, m_spd, m_hits;
    int m_mode, m_wait, m_cyc;
    bit m_hit, m_sl, m_sr;

    int y_max = 0;
    int y_min = 1000;
    int n_rhit = 0;
    int n_lhit = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = W / 2;
        m_y = H / 2;
        m_vx = 1;
        m_vy = 1;
        m_spd = 1;
        m_hits = 0;
        m_mode = 0;
        m_wait = 0;
        m_cyc = 0;
    endtask

    task automatic play_tick();
        int nx, ny, ny2, vy2, rp, lp;
        nx = m_x + m_vx * m_spd;
        ny = m_y + m_vy * m_spd;
        rp = int'(bus.right_paddle_pos);
        lp = int'(bus.left_paddle_pos);
        ny2 = ny;
        vy2 = m_vy;
        if (ny - BH <= 0) begin
            ny2 = BH;
            vy2 = 1;
        end else if (ny + BH >= H - 1) begin
            ny2 = H - 1 - BH;
            vy2 = -1;
        end
        if (m_vx > 0 && m_x + BH < RPX && nx + BH >= RPX &&
            iabs(m_y - rp) <= PH + BH) begin
            m_x = RPX - BH;
            m_vx = -1;
            m_hit = 1;
        end else if (m_vx < 0 && m_x - BH > LPX && nx - BH <= LPX &&
                     iabs(m_y - lp) <= PH + BH) begin
            m_x = LPX + BH;
            m_vx = 1;
            m_hit = 1;
        end else if (nx + BH >= W - 1) begin
            m_sl = 1;
            m_vx = 1;
        end else if (nx - BH <= 0) begin
            m_sr = 1;
            m_vx = -1;
        end else begin
            m_x = nx;
        end
        if (m_sl || m_sr) begin
            m_mode = 0;
            m_x = W / 2;
            m_y = H / 2;
            m_spd = 1;
            m_hits = 0;
        end else begin
            m_y = ny2;
            m_vy = vy2;
        end
        if (m_hit) begin
            m_hits++;
            if (m_hits == HPS) begin
                m_hits = 0;
                if (m_spd < MAXS) m_spd++;
            end
        end
    endtask

    // Model steps on every edge and queues the expected outputs.
    always @(posedge clk) begin
        snap_t s;
        m_hit = 0;
        m_sl = 0;
        m_sr = 0;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_cyc++;
            if (m_mode == 0) begin
                if (bus.serve) begin
                    m_mode = 1;
                    m_wait = 0;
                end
            end else if (m_cyc % DIV == 0) begin
                if (m_mode == 1) begin
                    m_wait++;
                    if (m_wait == ST) m_mode = 2;
                end else begin
                    play_tick();
                end
            end
        end
        s.x = m_x;
        s.y = m_y;
        s.act = (m_mode == 2);
        s.hit = m_hit;
        s.sl = m_sl;
        s.sr = m_sr;
        q.push_back(s);
    end

    // Monitor pops one expectation per clock and compares.
    always @(negedge clk) begin
        snap_t e;
        int gx, gy;
        if (q.size() > 0) begin
            e = q.pop_front();
            gx = int'(bus.ball_x_pos);
            gy = int'(bus.ball_y_pos);
            vectors++;
            if (gx != e.x || gy != e.y || bus.ball_active != e.act ||
                bus.hit != e.hit || bus.score_left != e.sl ||
                bus.score_right != e.sr) begin
                miscompares++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d act=%0b hit=%0b sl=%0b sr=%0b, expected x=%0d y=%0d act=%0b hit=%0b sl=%0b sr=%0b",
                         $time, gx, gy, bus.ball_active, bus.hit,
                         bus.score_left, bus.score_right,
                         e.x, e.y, e.act, e.hit, e.sl, e.sr);
            end
        end
        if (bus.ball_active) begin
            if (int'(bus.ball_y_pos) > y_max) y_max = int'(bus.ball_y_pos);
            if (int'(bus.ball_y_pos) < y_min) y_min = int'(bus.ball_y_pos);
        end
        if (bus.hit && bus.ball_x_pos == 10'd535) n_rhit++;
        if (bus.hit && bus.ball_x_pos == 10'd105) n_lhit++;
    end

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Paddle modes: 0 track ball, 1 far from ball, 2 random.
    function automatic int pad(input int md);
        if (md == 0) return m_y;
        if (md == 1) return (m_y > 240) ? 50 : 430;
        return int'($urandom_range(0, 479));
    endfunction

    task automatic cyc(input int lm, input int rm);
        @(negedge clk);
        bus.left_paddle_pos = 10'(pad(lm));
        bus.right_paddle_pos = 10'(pad(rm));
    endtask

    task automatic serve_pulse();
        @(negedge clk);
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
    endtask

    task automatic chk_centre(input string nm);
        chk({nm, "_x"}, int'(bus.ball_x_pos), 320);
        chk({nm, "_y"}, int'(bus.ball_y_pos), 240);
        chk({nm, "_active"}, int'(bus.ball_active), 0);
    endtask

    initial begin
        bit seen;
        bus.serve = 1'b1;
        bus.left_paddle_pos = 10'd240;
        bus.right_paddle_pos = 10'd240;
        model_reset();
        repeat (4) @(negedge clk);
        chk_centre("reset");
        chk("reset_pulses",
            int'({bus.hit, bus.score_left, bus.score_right}), 0);
        #2;
        reset_n = 1'b1;
        bus.serve = 1'b0;
        repeat (10) @(negedge clk);
        chk_centre("idle");

        serve_pulse();
        repeat (6000) cyc(0, 0);
        chk("bottom_clamp_y_max", y_max, 474);
        chk("top_clamp_y_min", y_min, 5);
        chk("right_hit_at_535", (n_rhit > 0) ? 1 : 0, 1);
        chk("left_hit_at_105", (n_lhit > 0) ? 1 : 0, 1);
        chk("still_active", int'(bus.ball_active), 1);

        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            cyc(0, 1);
            if (bus.score_left) begin
                seen = 1;
                chk_centre("score_left");
            end
        end
        if (!seen) chk("score_left_seen", 0, 1);

        serve_pulse();
        seen = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            cyc(1, 0);
            if (bus.score_right) begin
                seen = 1;
                chk_centre("score_right");
            end
        end
        if (!seen) chk("score_right_seen", 0, 1);

        serve_pulse();
        for (int i = 0; i < 3000; i++) begin
            cyc(2, 2);
            bus.serve = ($urandom_range(0, 15) == 0);
        end
        bus.serve = 1'b0;

        serve_pulse();
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(0, 0);
            if (bus.ball_active) seen = 1;
        end
        if (!seen) chk("play_reached", 0, 1);
        repeat (10) cyc(0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_centre("async_reset");
        chk("async_reset_pulses",
            int'({bus.hit, bus.score_left, bus.score_right}), 0);
        repeat (3) cyc(0, 0);
        #2;
        reset_n = 1'b1;
        repeat (20) cyc(0, 0);
        chk_centre("post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
